// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM arbiter and other round-robin arbiters.
// Provides the arbiter state encoding and a rotate-priority grant function.
package ram_arb_pkg;

  localparam int MAX_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Zero-padded requests above NUM_REQ never win, so a fixed MAX_REQ-wide
  // rotation gives the same answer as a NUM_REQ-wide one.
  function automatic logic [MAX_REQ-1:0] rr_next(input logic [IDX_W-1:0] last,
                                                 input logic [MAX_REQ-1:0] req);
    logic [MAX_REQ-1:0] g;
    logic               found;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      for (int j = 0; j < MAX_REQ; j++) begin
        if (!found && req[j] && (j == ((int'(last) + k) % MAX_REQ))) begin
          g[j]  = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: one-hot grant to the first requester
// found searching upward from i_last+1, wrapping around.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic [MAX_REQ-1:0] w_req_pad;
  logic [MAX_REQ-1:0] w_gnt_pad;

  assign w_req_pad = MAX_REQ'(i_req);
  assign w_gnt_pad = rr_next(i_last, w_req_pad);
  assign o_gnt     = w_gnt_pad[NUM_REQ-1:0];

  generate
    if (NUM_REQ < MAX_REQ) begin : g_pad
      logic w_unused_hi;
      assign w_unused_hi = |w_gnt_pad[MAX_REQ-1:NUM_REQ];
    end
  endgenerate

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NUM_REQ
// requesters, with burst lock and a one-cycle read tag for data steering.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  input  logic [NUM_REQ-1:0]            lock,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [DATA_WIDTH-1:0]         ram_data,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic                          ram_we,
  input  logic [DATA_WIDTH-1:0]         ram_q
);

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_e         r_state, w_state_next;
  logic [IDX_W-1:0]   r_last, w_last_next;
  logic [NUM_REQ-1:0] r_rd_tag;
  logic [NUM_REQ-1:0] w_pick, w_gnt;
  logic               w_hold;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req  (req),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  // While locked, r_last still names the owner because it was the last grant.
  always_comb begin
    w_hold       = 1'b0;
    w_gnt        = '0;
    w_last_next  = r_last;
    w_state_next = IDLE;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (j == int'(r_last)) begin
        w_hold = (r_state == LOCKED) && req[j] && lock[j];
      end
    end
    if (!rst) begin
      if (w_hold) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          w_gnt[j] = (j == int'(r_last));
        end
        w_state_next = LOCKED;
      end else begin
        w_gnt = w_pick;
        for (int j = 0; j < NUM_REQ; j++) begin
          if (w_pick[j]) begin
            w_last_next  = IDX_W'(j);
            w_state_next = lock[j] ? LOCKED : GRANT;
          end
        end
      end
    end
  end

  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_we   = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_gnt[j]) begin
        ram_addr = addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        ram_data = wdata[j*DATA_WIDTH +: DATA_WIDTH];
        ram_we   = we[j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= LAST_RST;
      r_rd_tag <= '0;
    end else begin
      r_state  <= w_state_next;
      r_last   <= w_last_next;
      r_rd_tag <= w_gnt & ~we;
    end
  end

  assign gnt    = w_gnt;
  assign rvalid = r_rd_tag;
  assign rdata  = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench: directed table on a 2-requester arbiter, hand-written
// reset/rotation sequences, and randomized traffic on a 4-requester arbiter.
module tb_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 2-requester instance
  logic [1:0]      req2, we2, lock2, gnt2, rvalid2;
  logic [2*AW-1:0] addr2;
  logic [2*DW-1:0] wdata2;
  logic [DW-1:0]   rdata2, ram_data2, ram_q2;
  logic [AW-1:0]   ram_addr2;
  logic            ram_we2;

  // 4-requester instance
  logic [3:0]      req4, we4, lock4, gnt4, rvalid4;
  logic [4*AW-1:0] addr4;
  logic [4*DW-1:0] wdata4;
  logic [DW-1:0]   rdata4, ram_data4, ram_q4;
  logic [AW-1:0]   ram_addr4;
  logic            ram_we4;

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .lock(lock2), .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2),
    .ram_data(ram_data2), .ram_addr(ram_addr2), .ram_we(ram_we2), .ram_q(ram_q2)
  );

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .we(we4), .addr(addr4), .wdata(wdata4),
    .lock(lock4), .gnt(gnt4), .rvalid(rvalid4), .rdata(rdata4),
    .ram_data(ram_data4), .ram_addr(ram_addr4), .ram_we(ram_we4), .ram_q(ram_q4)
  );

  // Single-port RAMs with registered address
  logic [DW-1:0] mem2 [0:(1<<AW)-1];
  logic [DW-1:0] mem4 [0:(1<<AW)-1];
  logic [AW-1:0] ra2, ra4;
  always @(posedge clk) begin
    if (ram_we2) mem2[ram_addr2] <= ram_data2;
    ra2 <= ram_addr2;
    if (ram_we4) mem4[ram_addr4] <= ram_data4;
    ra4 <= ram_addr4;
  end
  assign ram_q2 = mem2[ra2];
  assign ram_q4 = mem4[ra4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] req, we, lock;
    logic [9:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] g, rv;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic [1:0] req, we, lock, input logic [9:0] a0, a1,
                              input logic [7:0] d0, d1, input logic [1:0] g, rv,
                              input logic [7:0] rd);
    vec_t v;
    v.req = req; v.we = we; v.lock = lock; v.a0 = a0; v.a1 = a1;
    v.d0 = d0; v.d1 = d1; v.g = g; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  task automatic drive2(input logic [1:0] r, w, l, input logic [9:0] a0, a1,
                        input logic [7:0] d0, d1);
    req2 = r; we2 = w; lock2 = l; addr2 = {a1, a0}; wdata2 = {d1, d0};
  endtask

  // Reference model state for the 4-requester random phase
  int         m_last;
  int         m_owner;
  logic [7:0] m_mem [16];
  bit         m_known [16];
  int         pr_idx;
  bit         pr_known;
  logic [7:0] pr_data;

  initial begin
    logic [3:0] seq_gnt [9];
    logic [3:0] seq_req [9];
    int         g, base, idx;
    bit         hold;
    logic [9:0] a;
    logic [7:0] d;
    logic [3:0] exp_g;

    tbl[0]  = mk(2'b01, 2'b01, 2'b00, 10'd5, 10'd0, 8'hA5, 8'h00, 2'b01, 2'b00, 8'h00);
    tbl[1]  = mk(2'b01, 2'b00, 2'b00, 10'd5, 10'd0, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00);
    tbl[2]  = mk(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 2'b00, 2'b01, 8'hA5);
    tbl[3]  = mk(2'b11, 2'b11, 2'b00, 10'd3, 10'd7, 8'h33, 8'h77, 2'b10, 2'b00, 8'h00);
    tbl[4]  = mk(2'b01, 2'b01, 2'b00, 10'd3, 10'd0, 8'h33, 8'h00, 2'b01, 2'b00, 8'h00);
    tbl[5]  = mk(2'b11, 2'b00, 2'b00, 10'd3, 10'd7, 8'h00, 8'h00, 2'b10, 2'b00, 8'h00);
    tbl[6]  = mk(2'b11, 2'b00, 2'b00, 10'd3, 10'd7, 8'h00, 8'h00, 2'b01, 2'b10, 8'h77);
    tbl[7]  = mk(2'b11, 2'b00, 2'b00, 10'd3, 10'd7, 8'h00, 8'h00, 2'b10, 2'b01, 8'h33);
    tbl[8]  = mk(2'b11, 2'b00, 2'b00, 10'd3, 10'd7, 8'h00, 8'h00, 2'b01, 2'b10, 8'h77);
    tbl[9]  = mk(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 2'b00, 2'b01, 8'h33);
    tbl[10] = mk(2'b11, 2'b00, 2'b10, 10'd3, 10'd7, 8'h00, 8'h00, 2'b10, 2'b00, 8'h00);
    tbl[11] = mk(2'b11, 2'b00, 2'b10, 10'd3, 10'd7, 8'h00, 8'h00, 2'b10, 2'b10, 8'h77);
    tbl[12] = mk(2'b11, 2'b00, 2'b10, 10'd3, 10'd7, 8'h00, 8'h00, 2'b10, 2'b10, 8'h77);
    tbl[13] = mk(2'b11, 2'b00, 2'b10, 10'd3, 10'd7, 8'h00, 8'h00, 2'b10, 2'b10, 8'h77);
    tbl[14] = mk(2'b11, 2'b00, 2'b00, 10'd3, 10'd7, 8'h00, 8'h00, 2'b01, 2'b10, 8'h77);
    tbl[15] = mk(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 2'b00, 2'b01, 8'h33);
    tbl[16] = mk(2'b11, 2'b00, 2'b01, 10'd3, 10'd7, 8'h00, 8'h00, 2'b10, 2'b00, 8'h00);
    tbl[17] = mk(2'b11, 2'b00, 2'b01, 10'd3, 10'd7, 8'h00, 8'h00, 2'b01, 2'b10, 8'h77);
    tbl[18] = mk(2'b11, 2'b00, 2'b01, 10'd3, 10'd7, 8'h00, 8'h00, 2'b01, 2'b01, 8'h33);
    tbl[19] = mk(2'b10, 2'b00, 2'b01, 10'd3, 10'd7, 8'h00, 8'h00, 2'b10, 2'b01, 8'h33);
    tbl[20] = mk(2'b10, 2'b10, 2'b00, 10'd0, 10'd9, 8'h00, 8'h5A, 2'b10, 2'b10, 8'h77);
    tbl[21] = mk(2'b01, 2'b00, 2'b00, 10'd9, 10'd0, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00);
    tbl[22] = mk(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 2'b00, 2'b01, 8'h5A);

    // ---- reset: grants and writes suppressed even with requests present
    rst = 1'b1;
    drive2(2'b01, 2'b01, 2'b00, 10'd5, 10'd0, 8'hA5, 8'h00);
    req4 = 4'b1111; we4 = 4'b1111; lock4 = '0; addr4 = '0; wdata4 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt2",   32'(gnt2),    32'h0);
    chk("rst_we2",    32'(ram_we2), 32'h0);
    chk("rst_rv2",    32'(rvalid2), 32'h0);
    chk("rst_gnt4",   32'(gnt4),    32'h0);
    chk("rst_we4",    32'(ram_we4), 32'h0);
    $display("[TB] reset gnt2=%b we2=%b rv2=%b gnt4=%b", gnt2, ram_we2, rvalid2, gnt4);
    req4 = '0; we4 = '0;
    @(negedge clk);
    rst = 1'b0;

    // ---- directed table on the 2-requester arbiter
    for (int i = 0; i < 23; i++) begin
      drive2(tbl[i].req, tbl[i].we, tbl[i].lock, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      #1;
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt2), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_we", i),  32'(ram_we2), 32'(|(tbl[i].g & tbl[i].we)));
      chk($sformatf("tbl%0d_rv", i),  32'(rvalid2), 32'(tbl[i].rv));
      if (tbl[i].rv != 2'b00)
        chk($sformatf("tbl%0d_rdata", i), 32'(rdata2), 32'(tbl[i].rd));
      $display("[TB] vec %0d req=%b we=%b lock=%b gnt=%b rvalid=%b rdata=%h",
               i, req2, we2, lock2, gnt2, rvalid2, rdata2);
      @(negedge clk);
    end

    // ---- reset asserted the cycle after a granted read
    drive2(2'b11, 2'b00, 2'b00, 10'd3, 10'd7, 8'h00, 8'h00);
    #1;
    chk("mid_pre_gnt", 32'(gnt2), 32'h2);
    @(negedge clk);
    rst = 1'b1;
    drive2(2'b11, 2'b11, 2'b00, 10'd3, 10'd7, 8'hEE, 8'hEE);
    #1;
    chk("mid_rst_rv",  32'(rvalid2), 32'h0);
    chk("mid_rst_gnt", 32'(gnt2),    32'h0);
    chk("mid_rst_we",  32'(ram_we2), 32'h0);
    $display("[TB] midrst rvalid=%b gnt=%b we=%b", rvalid2, gnt2, ram_we2);
    @(negedge clk);
    rst = 1'b0;
    drive2(2'b11, 2'b00, 2'b00, 10'd3, 10'd7, 8'h00, 8'h00);
    #1;
    chk("post_rst_gnt0", 32'(gnt2), 32'h1);
    @(negedge clk);
    #1;
    chk("post_rst_gnt1", 32'(gnt2), 32'h2);
    chk("post_rst_rv0",  32'(rvalid2), 32'h1);
    chk("post_rst_rd0",  32'(rdata2), 32'h33);
    @(negedge clk);
    drive2(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00);
    #1;
    chk("post_rst_rv1",  32'(rvalid2), 32'h2);
    chk("post_rst_rd1",  32'(rdata2), 32'h77);
    $display("[TB] postrst rvalid=%b rdata=%h", rvalid2, rdata2);
    @(negedge clk);

    // ---- 4-requester rotation with requester 2 dropping out
    seq_req[0] = 4'b1111; seq_gnt[0] = 4'b0001;
    seq_req[1] = 4'b1111; seq_gnt[1] = 4'b0010;
    seq_req[2] = 4'b1111; seq_gnt[2] = 4'b0100;
    seq_req[3] = 4'b1111; seq_gnt[3] = 4'b1000;
    seq_req[4] = 4'b1111; seq_gnt[4] = 4'b0001;
    seq_req[5] = 4'b1011; seq_gnt[5] = 4'b0010;
    seq_req[6] = 4'b1011; seq_gnt[6] = 4'b1000;
    seq_req[7] = 4'b1011; seq_gnt[7] = 4'b0001;
    seq_req[8] = 4'b1011; seq_gnt[8] = 4'b0010;
    for (int i = 0; i < 9; i++) begin
      req4 = seq_req[i]; we4 = '0; lock4 = '0;
      #1;
      chk($sformatf("rot%0d_gnt", i), 32'(gnt4), 32'(seq_gnt[i]));
      $display("[TB] rot %0d req=%b gnt=%b", i, req4, gnt4);
      @(negedge clk);
    end

    // ---- randomized traffic on the 4-requester arbiter vs reference model
    rst = 1'b1;
    req4 = '0;
    @(negedge clk);
    rst = 1'b0;
    m_last  = 3;
    m_owner = -1;
    pr_idx  = -1;
    pr_known = 1'b0;
    pr_data = '0;
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = '0;
      m_known[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < 4; r++) begin
        req4[r]  = ($urandom_range(0, 9) < 6);
        we4[r]   = $urandom_range(0, 1) != 0;
        lock4[r] = ($urandom_range(0, 9) < 4);
        addr4[r*AW +: AW]  = AW'($urandom_range(0, 15));
        wdata4[r*DW +: DW] = DW'($urandom);
      end
      hold = (m_owner >= 0) && req4[m_owner] && lock4[m_owner];
      g = -1;
      if (hold) begin
        g = m_owner;
      end else begin
        base = (m_owner >= 0) ? m_owner : m_last;
        for (int k = 1; k <= 4; k++) begin
          idx = (base + k) % 4;
          if (g < 0 && req4[idx]) g = idx;
        end
      end
      exp_g = (g < 0) ? 4'b0000 : 4'(1 << g);
      a = (g < 0) ? '0 : addr4[g*AW +: AW];
      d = (g < 0) ? '0 : wdata4[g*DW +: DW];
      #1;
      chk("rnd_gnt",  32'(gnt4), 32'(exp_g));
      chk("rnd_we",   32'(ram_we4), 32'((g >= 0) && we4[g]));
      chk("rnd_addr", 32'(ram_addr4), 32'(a));
      if (g >= 0 && we4[g]) chk("rnd_wdata", 32'(ram_data4), 32'(d));
      chk("rnd_rv", 32'(rvalid4), (pr_idx < 0) ? 32'h0 : (32'h1 << pr_idx));
      if (pr_idx >= 0 && pr_known) chk("rnd_rdata", 32'(rdata4), 32'(pr_data));
      $display("[TB] rnd %0d req=%b lock=%b we=%b gnt=%b rvalid=%b", cyc, req4, lock4, we4, gnt4, rvalid4);
      pr_idx = -1;
      if (g >= 0) begin
        if (we4[g]) begin
          m_mem[a[3:0]] = d;
          m_known[a[3:0]] = 1'b1;
        end else begin
          pr_idx   = g;
          pr_known = m_known[a[3:0]];
          pr_data  = m_mem[a[3:0]];
        end
        if (!hold) m_last = g;
        m_owner = lock4[g] ? g : -1;
      end else begin
        m_owner = -1;
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
